multi_port_g_aetcam_array: RTL and testbench

//  Parametrised ternary CAM array: DEPTH words of WIDTH ternary bits (stored bit + don't-care mask bit).
//  NUM_PORTS independent search ports, each a fixed 2-cycle pipeline to a priority-encoded result.
//  One write port with valid/ready, a valid bit per entry, live occupancy count, and a bulk-clear sweep FSM.

---
 rtl/multi_port_g_aetcam_array.sv | 211 +++++++++++++++++++++
 tb/tb_multi_port_g_aetcam_array.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_port_g_aetcam_array.sv
// multi_port_g_aetcam_array
// Ternary CAM lookup engine. It holds DEPTH words of WIDTH ternary bits. Each
// word has a stored key, a don't-care mask and a valid bit.
// NUM_PORTS independent search ports each run a fixed two-stage pipeline:
//   - stage 1 registers the per-entry match vector;
//   - stage 2 registers the priority-encoded hit/multi/idx result.
// A single write port updates one entry per cycle.
// A bulk-clear sweep invalidates everything at once. It then zeroes the
// stored keys and masks one entry per cycle.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   wr_valid/ready    write handshake; wr_addr, wr_key, wr_mask, wr_en_entry
//   clr_req           pulse to start a bulk clear; busy while the sweep runs
//   entry_count       live number of valid entries
//   srch_valid/key    per-port search requests (port p key at [p*WIDTH +: WIDTH])
//   rslt_valid/hit/   per-port results two cycles after the request,
//   rslt_multi/idx    with idx at [p*IW +: IW]
module multi_port_g_aetcam_array #(
   parameter int WIDTH     = 16,
   parameter int DEPTH     = 32,
   parameter int NUM_PORTS = 2,
   localparam int IW       = $clog2(DEPTH),
   localparam int CW       = $clog2(DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic [IW-1:0]              wr_addr,
   input  logic [WIDTH-1:0]           wr_key,
   input  logic [WIDTH-1:0]           wr_mask,
   input  logic                       wr_en_entry,
   input  logic                       clr_req,
   output logic                       busy,
   output logic [CW-1:0]              entry_count,
   input  logic [NUM_PORTS-1:0]       srch_valid,
   input  logic [NUM_PORTS*WIDTH-1:0] srch_key,
   output logic [NUM_PORTS-1:0]       rslt_valid,
   output logic [NUM_PORTS-1:0]       rslt_hit,
   output logic [NUM_PORTS-1:0]       rslt_multi,
   output logic [NUM_PORTS*IW-1:0]    rslt_idx
);

   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

   state_t                          state_q;
   logic [IW-1:0]                   ptr_q;
   logic                            busy_q;

   logic [DEPTH-1:0]                valid_q, valid_d;
   logic [DEPTH-1:0][WIDTH-1:0]     key_q, key_d;
   logic [DEPTH-1:0][WIDTH-1:0]     mask_q, mask_d;
   logic [CW-1:0]                   count_q, count_d;

   logic [NUM_PORTS-1:0][DEPTH-1:0] match_q, match_d;
   logic [NUM_PORTS-1:0]            s1_valid_q, s1_valid_d;

   logic [NUM_PORTS-1:0]            rslt_valid_q, rslt_valid_d;
   logic [NUM_PORTS-1:0]            rslt_hit_q, rslt_hit_d;
   logic [NUM_PORTS-1:0]            rslt_multi_q, rslt_multi_d;
   logic [NUM_PORTS-1:0][IW-1:0]    rslt_idx_q, rslt_idx_d;

   logic                            clr_start;
   logic                            wr_fire;
   logic                            addr_ok;

   // Writes are refused while sweeping.
   // They are also refused in the very cycle a clear is requested, so a
   // write can never race the mass invalidation.
   assign wr_ready  = (state_q == ST_IDLE) & ~clr_req;
   assign clr_start = (state_q == ST_IDLE) & clr_req;
   assign wr_fire   = wr_valid & wr_ready;
   assign addr_ok   = 32'(wr_addr) < 32'(DEPTH);

   assign busy        = busy_q;
   assign entry_count = count_q;
   assign rslt_valid  = rslt_valid_q;
   assign rslt_hit    = rslt_hit_q;
   assign rslt_multi  = rslt_multi_q;
   assign rslt_idx    = rslt_idx_q;

   // Clear-sweep controller.
   // Entry into CLEAR coincides with the mass invalidation of the valid
   // bits. The sweep then visits every entry exactly once to scrub its key
   // and mask.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (clr_req) begin
                  state_q <= ST_CLEAR;
                  ptr_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            ST_CLEAR: begin
               if (ptr_q == IW'(DEPTH - 1)) begin
                  state_q <= ST_IDLE;
                  ptr_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  ptr_q <= ptr_q + IW'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Storage and occupancy update.
   // The clear, the sweep and a write never coincide, because wr_ready
   // excludes both clr_req and the CLEAR state.
   always_comb begin
      valid_d = valid_q;
      key_d   = key_q;
      mask_d  = mask_q;
      count_d = count_q;
      if (clr_start) begin
         valid_d = '0;
         count_d = '0;
      end else if (state_q == ST_CLEAR) begin
         key_d[ptr_q]  = '0;
         mask_d[ptr_q] = '0;
      end else if (wr_fire && addr_ok) begin
         key_d[wr_addr]   = wr_key;
         mask_d[wr_addr]  = wr_mask;
         valid_d[wr_addr] = wr_en_entry;
         if (wr_en_entry && !valid_q[wr_addr]) begin
            count_d = count_q + CW'(1);
         end else if (!wr_en_entry && valid_q[wr_addr]) begin
            count_d = count_q - CW'(1);
         end
      end
   end

   // Search stage 1.
   // Each entry is compared against the pre-write contents, so a write
   // accepted this cycle only affects searches sampled from the next cycle
   // onward.
   always_comb begin
      s1_valid_d = srch_valid;
      match_d    = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         for (int e = 0; e < DEPTH; e++) begin
            match_d[p][e] = valid_q[e] &
               (&((~(srch_key[p*WIDTH +: WIDTH] ^ key_q[e])) | mask_q[e]));
         end
      end
   end

   // Search stage 2.
   // This stage is a lowest-index priority encoder. "Multi" is detected by
   // clearing the lowest set bit and checking whether anything remains.
   // The results hold their previous values when no search completes.
   always_comb begin
      rslt_valid_d = s1_valid_q;
      rslt_hit_d   = rslt_hit_q;
      rslt_multi_d = rslt_multi_q;
      rslt_idx_d   = rslt_idx_q;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (s1_valid_q[p]) begin
            rslt_hit_d[p]   = |match_q[p];
            rslt_multi_d[p] = |(match_q[p] & (match_q[p] - 1'b1));
            rslt_idx_d[p]   = '0;
            for (int e = DEPTH - 1; e >= 0; e--) begin
               if (match_q[p][e]) begin
                  rslt_idx_d[p] = IW'(e);
               end
            end
         end
      end
   end

   // Datapath registers.
   // Reset flushes the pipeline so that no searches issued before reset
   // ever produce a strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q      <= '0;
         key_q        <= '0;
         mask_q       <= '0;
         count_q      <= '0;
         match_q      <= '0;
         s1_valid_q   <= '0;
         rslt_valid_q <= '0;
         rslt_hit_q   <= '0;
         rslt_multi_q <= '0;
         rslt_idx_q   <= '0;
      end else begin
         valid_q      <= valid_d;
         key_q        <= key_d;
         mask_q       <= mask_d;
         count_q      <= count_d;
         match_q      <= match_d;
         s1_valid_q   <= s1_valid_d;
         rslt_valid_q <= rslt_valid_d;
         rslt_hit_q   <= rslt_hit_d;
         rslt_multi_q <= rslt_multi_d;
         rslt_idx_q   <= rslt_idx_d;
      end
   end

endmodule

// File: tb/tb_multi_port_g_aetcam_array.sv
// tb_multi_port_g_aetcam_array
// Scoreboard bench for the ternary CAM array.
// The driver advances one cycle per call. Every search it issues is
// resolved against a plain array model of the CAM, and the result is
// queued. A free-running monitor pops one queued result for every result
// strobe. Between strobes it checks that the result outputs hold steady.
module tb_multi_port_g_aetcam_array;

   localparam int WIDTH = 16;
   localparam int DEPTH = 32;
   localparam int NP    = 2;
   localparam int IW    = 5;
   localparam int CW    = 6;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  wrValid = 1'b0;
   logic                  wrReady;
   logic [IW-1:0]         wrAddr = '0;
   logic [WIDTH-1:0]      wrKey = '0;
   logic [WIDTH-1:0]      wrMask = '0;
   logic                  wrEnEntry = 1'b0;
   logic                  clrReq = 1'b0;
   logic                  busy;
   logic [CW-1:0]         entryCount;
   logic [NP-1:0]         srchValid = '0;
   logic [NP*WIDTH-1:0]   srchKey = '0;
   logic [NP-1:0]         rsltValid;
   logic [NP-1:0]         rsltHit;
   logic [NP-1:0]         rsltMulti;
   logic [NP*IW-1:0]      rsltIdx;

   int checkCnt = 0;
   int errCnt   = 0;

   // Reference model: contents, occupancy and remaining sweep cycles.
   logic             refValid [DEPTH];
   logic [WIDTH-1:0] refKey   [DEPTH];
   logic [WIDTH-1:0] refMask  [DEPTH];
   int               refCount;
   int               clearLeft;

   typedef struct {
      int   port;
      logic hit;
      logic multi;
      int   idx;
   } res_t;

   res_t expQ[$];
   int   lastHit   [NP];
   int   lastMulti [NP];
   int   lastIdx   [NP];

   multi_port_g_aetcam_array #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_PORTS(NP)
   ) dut (
      .clk(clk), .rst(rst),
      .wr_valid(wrValid), .wr_ready(wrReady), .wr_addr(wrAddr),
      .wr_key(wrKey), .wr_mask(wrMask), .wr_en_entry(wrEnEntry),
      .clr_req(clrReq), .busy(busy), .entry_count(entryCount),
      .srch_valid(srchValid), .srch_key(srchKey),
      .rslt_valid(rsltValid), .rslt_hit(rsltHit),
      .rslt_multi(rsltMulti), .rslt_idx(rsltIdx)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int act, input int exp);
      checkCnt++;
      if (act != exp) begin
         errCnt++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Resolves a search from the model by counting every matching word.
   function automatic res_t lookup(input int port, input logic [WIDTH-1:0] k);
      res_t r;
      int   n;
      n       = 0;
      r.port  = port;
      r.idx   = 0;
      for (int e = 0; e < DEPTH; e++) begin
         if (refValid[e] && (((k ^ refKey[e]) & ~refMask[e]) == '0)) begin
            if (n == 0) r.idx = e;
            n++;
         end
      end
      r.hit   = (n > 0);
      r.multi = (n >= 2);
      return r;
   endfunction

   task automatic resetModel();
      for (int e = 0; e < DEPTH; e++) begin
         refValid[e] = 1'b0;
         refKey[e]   = '0;
         refMask[e]  = '0;
      end
      refCount  = 0;
      clearLeft = 0;
      expQ.delete();
      for (int p = 0; p < NP; p++) begin
         lastHit[p]   = 0;
         lastMulti[p] = 0;
         lastIdx[p]   = 0;
      end
   endtask

   // Applies one clock edge to the model.
   // Searches see the contents from before this edge.
   task automatic modelEdge();
      for (int p = 0; p < NP; p++) begin
         if (srchValid[p]) expQ.push_back(lookup(p, srchKey[p*WIDTH +: WIDTH]));
      end
      if (clearLeft > 0) begin
         clearLeft--;
      end else if (clrReq) begin
         for (int e = 0; e < DEPTH; e++) begin
            refValid[e] = 1'b0;
            refKey[e]   = '0;
            refMask[e]  = '0;
         end
         refCount  = 0;
         clearLeft = DEPTH;
      end else if (wrValid) begin
         if (wrEnEntry && !refValid[wrAddr]) refCount++;
         if (!wrEnEntry && refValid[wrAddr]) refCount--;
         refValid[wrAddr] = wrEnEntry;
         refKey[wrAddr]   = wrKey;
         refMask[wrAddr]  = wrMask;
      end
   endtask

   // Drives one cycle of inputs.
   // Called just after a rising edge. It checks the status outputs at the
   // falling edge, then lets the model take the next rising edge.
   task automatic applyStimulus(input logic wv, input int addr,
                                input logic [WIDTH-1:0] k, input logic [WIDTH-1:0] m,
                                input logic en, input logic clr, input logic [NP-1:0] sv,
                                input logic [WIDTH-1:0] k0, input logic [WIDTH-1:0] k1);
      wrValid   = wv;
      wrAddr    = IW'(addr);
      wrKey     = k;
      wrMask    = m;
      wrEnEntry = en;
      clrReq    = clr;
      srchValid = sv;
      srchKey   = {k1, k0};
      @(negedge clk);
      checkOutput("wr_ready", int'(wrReady), int'((clearLeft == 0) && !clr));
      checkOutput("busy", int'(busy), int'(clearLeft > 0));
      checkOutput("entry_count", int'(entryCount), refCount);
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
   endtask

   // Asserts reset between edges and checks that outputs clear at once.
   task automatic doReset();
      rst       = 1'b1;
      wrValid   = 1'b0;
      clrReq    = 1'b0;
      srchValid = '0;
      #1;
      checkOutput("rst busy", int'(busy), 0);
      checkOutput("rst entry_count", int'(entryCount), 0);
      checkOutput("rst rslt_valid", int'(rsltValid), 0);
      checkOutput("rst rslt_hit", int'(rsltHit), 0);
      checkOutput("rst rslt_multi", int'(rsltMulti), 0);
      checkOutput("rst rslt_idx", int'(rsltIdx), 0);
      checkOutput("rst wr_ready", int'(wrReady), 1);
      resetModel();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Monitor.
   // Each strobe consumes the oldest queued result for its port. Quiet
   // cycles must show the last reported values.
   always @(negedge clk) begin
      if (!rst) begin
         for (int p = 0; p < NP; p++) begin
            if (rsltValid[p]) begin
               int found;
               found = -1;
               for (int i = 0; i < expQ.size(); i++) begin
                  if (expQ[i].port == p) begin
                     found = i;
                     break;
                  end
               end
               if (found < 0) begin
                  checkOutput($sformatf("p%0d unexpected strobe", p), 1, 0);
               end else begin
                  checkOutput($sformatf("p%0d hit", p), int'(rsltHit[p]), int'(expQ[found].hit));
                  checkOutput($sformatf("p%0d multi", p), int'(rsltMulti[p]), int'(expQ[found].multi));
                  checkOutput($sformatf("p%0d idx", p), int'(rsltIdx[p*IW +: IW]), expQ[found].idx);
                  lastHit[p]   = int'(expQ[found].hit);
                  lastMulti[p] = int'(expQ[found].multi);
                  lastIdx[p]   = expQ[found].idx;
                  expQ.delete(found);
               end
            end else begin
               checkOutput($sformatf("p%0d hold", p),
                           {int'(rsltHit[p]), int'(rsltMulti[p]), int'(rsltIdx[p*IW +: IW])} == {lastHit[p], lastMulti[p], lastIdx[p]} ? 1 : 0, 1);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [WIDTH-1:0] pool [4];
      pool[0] = 16'h1234;
      pool[1] = 16'hAAAA;
      pool[2] = 16'h0F0F;
      pool[3] = 16'h5A5A;
      resetModel();
      @(posedge clk);
      #1;
      doReset();

      // Single exact entry.
      applyStimulus(1, 5, 16'h1234, 16'h0000, 1, 0, 2'b00, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 2'b01, 16'h1234, 0);
      idle(3);

      // Masked entry below an exact one: multi-hit and priority.
      applyStimulus(1, 3, 16'h12F0, 16'h00FF, 1, 0, 2'b00, 0, 0);
      applyStimulus(1, 9, 16'h1234, 16'h0000, 1, 0, 2'b00, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 2'b11, 16'h1234, 16'h12AB);
      applyStimulus(0, 0, 0, 0, 0, 0, 2'b01, 16'h5555, 0);
      idle(3);

      // Write/search ordering on both ports.
      applyStimulus(1, 7, 16'hAAAA, 16'h0000, 1, 0, 2'b11, 16'hAAAA, 16'hAAAA);
      applyStimulus(0, 0, 0, 0, 0, 0, 2'b11, 16'hAAAA, 16'hAAAA);
      idle(3);

      // Overwrite, invalidate, invalidate again, then search the old key.
      applyStimulus(1, 5, 16'h7777, 16'h0000, 1, 0, 2'b00, 0, 0);
      applyStimulus(1, 5, 16'h7777, 16'h0000, 0, 0, 2'b00, 0, 0);
      applyStimulus(1, 5, 16'h7777, 16'h0000, 0, 0, 2'b00, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 2'b11, 16'h7777, 16'h7777);
      idle(3);

      // Clear requested together with a write, searches during the sweep.
      applyStimulus(1, 20, 16'hBEEF, 16'h0000, 1, 1, 2'b11, 16'hAAAA, 16'h1234);
      for (int i = 0; i < DEPTH + 2; i++)
         applyStimulus(1, 20, 16'hBEEF, 16'h0000, 1, 0, 2'b11, 16'hAAAA, 16'hBEEF);
      idle(3);

      // Reset part-way through a sweep with searches in flight.
      applyStimulus(1, 1, 16'hC0DE, 16'h0000, 1, 0, 2'b00, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 2'b11, 16'hC0DE, 16'hC0DE);
      for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0, 0, 2'b11, 16'hC0DE, 0);
      doReset();
      applyStimulus(1, 2, 16'hC0DE, 16'h0000, 1, 0, 2'b00, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 2'b11, 16'hC0DE, 16'hC0DF);
      idle(3);

      // Randomized traffic around a small key pool.
      for (int i = 0; i < 400; i++) begin
         logic [WIDTH-1:0] k, m, k0, k1;
         k  = pool[$urandom_range(0, 3)];
         m  = WIDTH'($urandom & $urandom & $urandom);
         k0 = pool[$urandom_range(0, 3)] ^ (($urandom_range(0, 3) == 0) ? WIDTH'(1 << $urandom_range(0, 15)) : '0);
         k1 = pool[$urandom_range(0, 3)];
         applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, DEPTH - 1), k, m,
                       $urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0,
                       NP'($urandom_range(0, 3)), k0, k1);
      end
      idle(4);
      checkOutput("scoreboard drained", expQ.size(), 0);

      $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
      $finish;
   end

endmodule
